// File: rtl/program_loader.sv
// Boot-time loader: receives a framed byte stream (length, payload, checksum)
// from the host, writes the payload to memory and holds the CPU until a good load.
module program_loader #(
    parameter logic [7:0]  BASE_ADDR      = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    // Idle counter only needs to reach TIMEOUT_CYCLES-1 before the limit edge.
    localparam int unsigned IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        stateNext;
    logic [8:0]    remaining;
    logic [7:0]    acc;
    logic [7:0]    wrAddr;
    logic [IW-1:0] idleCnt;

    logic       loading;
    logic       xfer;
    logic       timedOut;
    logic [7:0] checkSum;

    assign loading  = (state == LEN) || (state == DATA) || (state == CHECK);
    assign xfer     = in_valid && loading;
    assign timedOut = (TIMEOUT_CYCLES != 0) && loading && !xfer && (idleCnt == IDLE_LIMIT);
    assign checkSum = acc + in_data;

    assign in_ready   = loading;
    assign cpu_hold   = (state != DONE);
    assign load_done  = (state == DONE);
    assign load_error = (state == ERROR);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = LEN;
            LEN:     if (xfer) stateNext = DATA;
            DATA:    if (xfer && remaining == 9'd1) stateNext = CHECK;
            CHECK:   if (xfer) stateNext = (checkSum == 8'h00) ? DONE : ERROR;
            DONE:    if (start) stateNext = LEN;
            ERROR:   if (start) stateNext = LEN;
            default: stateNext = IDLE;
        endcase
        // A transfer on the limit cycle suppresses timedOut, so it wins.
        if (timedOut) stateNext = ERROR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            acc       <= '0;
            wrAddr    <= BASE_ADDR;
            idleCnt   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
        end else begin
            state  <= stateNext;
            mem_we <= 1'b0;

            if (!loading || xfer) begin
                idleCnt <= '0;
            end else begin
                idleCnt <= idleCnt + 1'b1;
            end

            if (xfer) begin
                case (state)
                    LEN: begin
                        remaining <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                        acc       <= in_data;
                        wrAddr    <= BASE_ADDR;
                    end
                    DATA: begin
                        acc       <= acc + in_data;
                        remaining <= remaining - 9'd1;
                        wrAddr    <= wrAddr + 8'd1;
                        mem_we    <= 1'b1;
                        mem_addr  <= wrAddr;
                        mem_wdata <= in_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: frames are generated with $urandom and the
// expected memory writes and final status come from a frame-level model.
module tb_program_loader;

    localparam logic [7:0]  BASE = 8'hF0;
    localparam int unsigned TMO  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       load_done;
    logic       load_error;

    program_loader #(
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  data;
        int unsigned when;
    } wr_t;

    wr_t         expQ[$];
    logic [7:0]  pay[$];
    int unsigned checks = 0;
    int unsigned fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write, in the expected cycle.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write (cycle %0d)",
                         mem_addr, mem_wdata, cyc);
            end else begin
                e = expQ.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", 32'(mem_wdata), 32'(e.data));
                check("wr_cycle", cyc, e.when);
            end
        end
    end

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; returns the number of the edge it transferred on.
    task automatic sendByte(input logic [7:0] b, input int unsigned gap, input bit isPayload,
                            input logic [7:0] addr, input bit noiseStart, output int unsigned edgeNo);
        int unsigned waited = 0;
        for (int unsigned i = 0; i < gap; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        start    = noiseStart;
        #1;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL handshake: got in_ready 0 for 20 cycles expected 1");
            edgeNo = 0;
        end else begin
            edgeNo = cyc + 1;
            if (isPayload) expQ.push_back('{addr, b, cyc + 1});
        end
        @(posedge clk);
    endtask

    function automatic int unsigned pickGap(input int unsigned mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return $urandom_range(3, 0);
    endfunction

    // Model: frame good iff (length byte + payload + checksum) mod 256 == 0.
    task automatic runFrame(input int unsigned len, input logic [7:0] chk,
                            input int unsigned gapMode, input bit noise);
        int unsigned e;
        int unsigned total;
        logic [7:0]  lenByte;
        bit          ok;
        lenByte = 8'(len % 256);
        total   = lenByte;
        pulseStart();
        sendByte(lenByte, pickGap(gapMode), 1'b0, 8'h00, 1'b0, e);
        for (int unsigned i = 0; i < len; i++) begin
            total += pay[i];
            sendByte(pay[i], pickGap(gapMode), 1'b1, 8'((BASE + i) % 256), noise, e);
        end
        total += chk;
        ok = (total % 256) == 0;
        sendByte(chk, pickGap(gapMode), 1'b0, 8'h00, 1'b0, e);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        check("load_done", 32'(load_done), 32'(ok));
        check("load_error", 32'(load_error), 32'(!ok));
        check("cpu_hold", 32'(cpu_hold), 32'(!ok));
    endtask

    function automatic logic [7:0] goodChk(input int unsigned len);
        int unsigned s = len % 256;
        for (int unsigned i = 0; i < len; i++) s += pay[i];
        return 8'((256 - (s % 256)) % 256);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned e;
        int unsigned len;
        logic [7:0]  c;

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'(BASE));
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
        reset = 1'b0;

        // Good load, back to back
        pay = '{8'h12, 8'h34, 8'h56};
        runFrame(3, 8'h61, 0, 1'b0);

        // Bad checksum, then a restart with the good stream
        runFrame(3, 8'h60, 0, 1'b0);
        runFrame(3, 8'h61, 0, 1'b0);

        // Throttled host with start noise during the payload
        runFrame(3, 8'h61, 1, 1'b1);

        // Wrap with 256-byte load
        pay.delete();
        for (int unsigned i = 0; i < 256; i++) pay.push_back(8'(i));
        runFrame(256, goodChk(256), 0, 1'b0);

        // Random frames, good and bad checksums
        for (int unsigned f = 0; f < 12; f++) begin
            pay.delete();
            len = $urandom_range(20, 1);
            for (int unsigned i = 0; i < len; i++) pay.push_back(8'($urandom_range(255, 0)));
            c = goodChk(len);
            if ($urandom_range(1, 0) == 1) c = c + 8'($urandom_range(255, 1));
            runFrame(len, c, 2, $urandom_range(1, 0) == 1);
        end

        // Timeout after one payload byte
        pulseStart();
        sendByte(8'h02, 0, 1'b0, 8'h00, 1'b0, e);
        sendByte(8'hAA, 0, 1'b1, BASE, 1'b0, e);
        @(negedge clk);
        in_valid = 1'b0;
        while (cyc < e + 7) @(negedge clk);
        check("tmo_not_yet", 32'(load_error), 32'd0);
        check("tmo_ready_still", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("tmo_error", 32'(load_error), 32'd1);
        check("tmo_ready", 32'(in_ready), 32'd0);
        check("tmo_hold", 32'(cpu_hold), 32'd1);
        check("tmo_done", 32'(load_done), 32'd0);
        repeat (4) @(negedge clk);

        // Reset mid-load, coinciding with an offered byte and a start pulse
        pulseStart();
        sendByte(8'h05, 0, 1'b0, 8'h00, 1'b0, e);
        sendByte(8'h11, 0, 1'b1, BASE, 1'b0, e);
        @(negedge clk);
        reset    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h22;
        @(negedge clk);
        check("mid_rst_mem_we", 32'(mem_we), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_hold", 32'(cpu_hold), 32'd1);
        check("mid_rst_done", 32'(load_done), 32'd0);
        check("mid_rst_error", 32'(load_error), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'(BASE));
        check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_idle_ready", 32'(in_ready), 32'd0);
        pay = '{8'h12, 8'h34, 8'h56};
        runFrame(3, 8'h61, 0, 1'b0);

        repeat (4) @(negedge clk);
        check("pending_writes", expQ.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
